day1_mux2: RTL and testbench
============================

Name: day1_mux2

Overview:
- 2:1 data-path multiplexer with parameterised width.
- Combinational output `y_o` selects `a_i` when `sel_i`=1 and `b_i` when `sel_i`=0, with zero latency.
- Also provides a registered copy of the selected data and a saturating count of select transitions, for downstream timing closure and debug visibility.
- Sits on data paths where a single select steers one of two operand buses.

Parameters:
- WIDTH, 8, bit width of `a_i`, `b_i`, `y_o` and `y_q_o`.
- CNT_W, 16, bit width of the select-change counter `sel_chg_cnt_o`.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- a_i  input  WIDTH  data operand selected when `sel_i`=1.
- b_i  input  WIDTH  data operand selected when `sel_i`=0.
- sel_i  input  1  select.
- y_o  output  WIDTH  combinational mux result.
- y_q_o  output  WIDTH  registered mux result, one cycle behind `y_o`.
- sel_chg_cnt_o  output  CNT_W  number of sampled `sel_i` value changes, saturating.

Behaviour:
- Combinational path:
  - `y_o` = `a_i` when `sel_i`=1, `b_i` when `sel_i`=0.
  - Purely combinational and independent of `clk_i` and `rst_i`: valid during reset and before the first clock edge.
  - Settles within the same delta/propagation time as input changes.
  - No latch is inferred; all bits are driven in every select state.
- Registered path:
  - On each rising `clk_i` with `rst_i`=0, `y_q_o` <= current `y_o` value. Latency is exactly 1 cycle.
  - On a rising `clk_i` with `rst_i`=1, `y_q_o` <= 0.
- Select-change tracking:
  - An internal register `sel_q` holds `sel_i` sampled at the previous edge.
  - On reset, `sel_q` <= 0 and `sel_chg_cnt_o` <= 0.
  - On each non-reset edge:
    - If `sel_i` != `sel_q`, `sel_chg_cnt_o` increments by 1.
    - `sel_q` <= `sel_i`.
  - The counter saturates at all-ones (2^CNT_W-1) and never wraps.
- Reset values:
  - `y_q_o`=0, `sel_chg_cnt_o`=0.
  - `y_o` has no reset value; it always reflects the inputs.
- Boundary conditions:
  - Reset asserted mid-operation: registered state clears at that edge. `y_o` keeps tracking the inputs.
  - First non-reset edge after reset with `sel_i`=1 counts as one change, because `sel_q` was reset to 0.
  - Simultaneous data and select change: `y_o` reflects new select with new data. `y_q_o` captures whatever `y_o` shows at the edge.
  - Equal operands (`a_i`==`b_i`): output equals that value regardless of select. The counter still counts select toggles.
  - Reset and saturation: reset overrides saturation and clears the counter.

Test Plan:
- `a_i`=8'hFF, `b_i`=8'h00, `sel_i`=0, wait 10 time units with no clock dependence -> `y_o`=8'h00.
- Same operands, `sel_i`=1, wait 10 -> `y_o`=8'hFF. Then swap to `a_i`=8'h3C, `b_i`=8'hA5 -> `y_o`=8'h3C immediately. Set `sel_i`=0 -> `y_o`=8'hA5.
- Pulse `rst_i` for 1 edge -> `y_q_o`=0 and `sel_chg_cnt_o`=0. Then `sel_i`=0, `b_i`=8'h5A, one edge -> `y_q_o`=8'h5A. Verify `y_q_o` lags `y_o` by exactly one edge after each operand change.
- Toggle `sel_i` 0,1,1,0,1 on successive edges after reset -> `sel_chg_cnt_o` = 0,1,1,2,3.
- CNT_W=2, toggle `sel_i` every edge for 6 edges -> `sel_chg_cnt_o` reaches 3 and holds at 3. Assert `rst_i` mid-stream -> counter reads 0 after that edge.
- Assert `rst_i` continuously while varying `sel_i`, `a_i` and `b_i` -> `y_o` follows the mux function, `y_q_o`=0, `sel_chg_cnt_o`=0 throughout.

Source files
------------

// File: rtl/day1_mux2.sv
// 2:1 data-path multiplexer with a zero-latency output, a registered copy of the
// selected data and a saturating count of sampled select changes.
module day1_mux2 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] y_q_o,
    output logic [CNT_W-1:0] sel_chg_cnt_o
);

    logic [WIDTH-1:0] w_y;
    logic             w_sel_chg;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_y_q;
    logic             r_sel_q;
    logic [CNT_W-1:0] r_sel_chg_cnt;

    // Zero-latency select; valid during reset and before the first edge.
    assign w_y       = sel_i ? a_i : b_i;
    assign w_sel_chg = (sel_i != r_sel_q);
    assign w_cnt_sat = (r_sel_chg_cnt == {CNT_W{1'b1}});

    // Registered copy of the mux result and select-change tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_y_q         <= '0;
            r_sel_q       <= 1'b0;
            r_sel_chg_cnt <= '0;
        end else begin
            r_y_q   <= w_y;
            r_sel_q <= sel_i;
            if (w_sel_chg && !w_cnt_sat) begin
                r_sel_chg_cnt <= r_sel_chg_cnt + CNT_W'(1);
            end
        end
    end

    assign y_o           = w_y;
    assign y_q_o         = r_y_q;
    assign sel_chg_cnt_o = r_sel_chg_cnt;

endmodule

// File: tb/tb_day1_mux2.sv
// Self-checking bench for day1_mux2: vector table plus hand sequences, with a
// scoreboard queue holding the expected registered outputs for each edge.
module tb_day1_mux2;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sel_i;
    logic [WIDTH-1:0] y_o;
    logic [WIDTH-1:0] y_q_o;
    logic [CNT_W-1:0] sel_chg_cnt_o;
    logic [WIDTH-1:0] y2_o;
    logic [WIDTH-1:0] y2_q_o;
    logic [1:0]       cnt2_o;

    day1_mux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .sel_i(sel_i),
        .y_o(y_o), .y_q_o(y_q_o), .sel_chg_cnt_o(sel_chg_cnt_o)
    );

    day1_mux2 #(.WIDTH(WIDTH), .CNT_W(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .sel_i(sel_i),
        .y_o(y2_o), .y_q_o(y2_q_o), .sel_chg_cnt_o(cnt2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
    } vec_t;

    typedef struct {
        logic [7:0]  yq;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the registered outputs
    logic        m_sel_q = 1'b0;
    logic [15:0] m_cnt   = '0;
    logic [1:0]  m_cnt2  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check comb output, push expectation, check after edge.
    task automatic step(input logic r, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_y);
        exp_t e;
        exp_t got;
        @(negedge clk_i);
        rst_i = r; sel_i = s; a_i = a; b_i = b;
        #1;
        chk("y_o", 32'(y_o), 32'(exp_y));
        if (r) begin
            m_sel_q = 1'b0; m_cnt = '0; m_cnt2 = '0;
            e.yq = '0;
        end else begin
            if (s != m_sel_q) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
            end
            m_sel_q = s;
            e.yq = s ? a : b;
        end
        e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk("y_q_o", 32'(y_q_o), 32'(got.yq));
            chk("sel_chg_cnt_o", 32'(sel_chg_cnt_o), 32'(got.cnt));
            chk("cnt2_o", 32'(cnt2_o), 32'(got.cnt2));
            chk("y2_q_o", 32'(y2_q_o), 32'(got.yq));
        end
    endtask

    vec_t vecs[15];
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;

    initial begin
        // Combinational path before any meaningful clocking (reset held)
        rst_i = 1'b1; sel_i = 1'b0; a_i = 8'hFF; b_i = 8'h00;
        #10 chk("comb_sel0", 32'(y_o), 32'h00);
        sel_i = 1'b1;
        #10 chk("comb_sel1", 32'(y_o), 32'hFF);
        a_i = 8'h3C; b_i = 8'hA5;
        #1 chk("comb_swap", 32'(y_o), 32'h3C);
        sel_i = 1'b0;
        #1 chk("comb_sel0b", 32'(y_o), 32'hA5);
        @(posedge clk_i); #1;
        chk("rst_y_q_o", 32'(y_q_o), 32'h0);
        chk("rst_cnt", 32'(sel_chg_cnt_o), 32'h0);

        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A};
        vecs[2]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h3C};
        vecs[3]  = '{1'b0, 1'b1, 8'h3C, 8'h11, 8'h3C};
        vecs[4]  = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5};
        vecs[5]  = '{1'b0, 1'b1, 8'h77, 8'h77, 8'h77};
        vecs[6]  = '{1'b0, 1'b0, 8'h77, 8'h77, 8'h77};
        vecs[7]  = '{1'b1, 1'b1, 8'h12, 8'h34, 8'h12};
        vecs[8]  = '{1'b0, 1'b1, 8'hAB, 8'hCD, 8'hAB};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h01, 8'h02, 8'h02};
        vecs[11] = '{1'b0, 1'b1, 8'h03, 8'h04, 8'h03};
        vecs[12] = '{1'b0, 1'b1, 8'h05, 8'h06, 8'h05};
        vecs[13] = '{1'b0, 1'b0, 8'h07, 8'h08, 8'h08};
        vecs[14] = '{1'b0, 1'b1, 8'h09, 8'h0A, 8'h09};
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_y);
        end
        // Sequence 0,1,1,0,1 after reset must have counted exactly three changes
        chk("seq_cnt", 32'(sel_chg_cnt_o), 32'd3);

        // Saturation on the 2-bit counter: toggle every edge after reset
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            rs = (i % 2 == 0);
            step(1'b0, rs, ra, rb, rs ? ra : rb);
        end
        chk("sat_cnt2", 32'(cnt2_o), 32'd3);
        chk("sat_cnt16", 32'(sel_chg_cnt_o), 32'd6);
        step(1'b1, 1'b1, 8'hC3, 8'h3C, 8'hC3);
        chk("sat_rst_cnt2", 32'(cnt2_o), 32'd0);

        // Reset held while inputs vary
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            step(1'b1, rs, ra, rb, rs ? ra : rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
